// File: rtl/multicycle_control.sv
// Main control FSM for the 32-bit RISC-V multicycle datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every
// mux select, write enable and the 4-bit ALU control code.
module multicycle_control #(
  parameter bit ENABLE_BNE      = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,          // active low, asynchronous
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_source,
  output logic [3:0] alu_control,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  state_t state_q, state_d;

  // Instruction classification; IR is stable from DECODE to retirement.
  logic f3_alu, is_mem, is_r, is_i, is_br;
  logic [3:0] alu_fn;

  assign f3_alu = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign is_mem = ((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == 3'b010);
  // R-type: funct7_b5 only selects SUB under funct3 000; elsewhere it must be 0.
  assign is_r   = (opcode == OP_R) && f3_alu && ((funct3 == 3'b000) || !funct7_b5);
  assign is_i   = (opcode == OP_I) && f3_alu;
  assign is_br  = (opcode == OP_BR) &&
                  ((funct3 == 3'b000) || (ENABLE_BNE && (funct3 == 3'b001)));

  // ALU function shared by R-type and I-type arithmetic.
  always_comb begin
    case (funct3)
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // State register with asynchronous return to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and output decode; enables are masked while in reset.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 1'b0;
    alu_control   = ALU_ADD;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        pc_source = 1'b1;
        pc_write  = 1'b1;
        if (is_mem)               state_d = S_MEM_ADDR;
        else if (is_r)            state_d = S_EXEC_R;
        else if (is_i)            state_d = S_EXEC_I;
        else if (is_br)           state_d = S_BRANCH;
        else if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
        else begin
          state_d       = S_FETCH;
          instr_retired = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d        = 1'b1;
        mem_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = ((funct3 == 3'b000) && funct7_b5) ? ALU_SUB : alu_fn;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = alu_fn;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_control   = ALU_SUB;
        pc_source     = 1'b1;
        instr_retired = 1'b1;
        pc_write      = funct3[0] ? ~zero : zero;   // bne : beq
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      pc_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      ir_write      = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// per-cycle output vectors, a monitor pops and compares on each negedge.
// dut1 uses default parameters, dut2 has TRAP_ON_ILLEGAL=0, ENABLE_BNE=0.
module tb_multicycle_control;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_ = 4'b0001;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iod, mr, mw, irw, m2r, rw, sa;
    logic [1:0] sb;
    logic       ps;
    logic [3:0] ctl;
    logic       ret, ill;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic       probe = 1'b0;
  logic       done = 1'b0;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5, zero;

  logic       pc_write_1, i_or_d_1, mem_read_1, mem_write_1, ir_write_1, mem_to_reg_1;
  logic       reg_write_1, alu_src_a_1, pc_source_1, instr_retired_1, illegal_1;
  logic [1:0] alu_src_b_1;
  logic [3:0] alu_control_1, state_1;
  logic       pc_write_2, i_or_d_2, mem_read_2, mem_write_2, ir_write_2, mem_to_reg_2;
  logic       reg_write_2, alu_src_a_2, pc_source_2, instr_retired_2, illegal_2;
  logic [1:0] alu_src_b_2;
  logic [3:0] alu_control_2, state_2;

  multicycle_control dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .pc_write(pc_write_1), .i_or_d(i_or_d_1), .mem_read(mem_read_1),
    .mem_write(mem_write_1), .ir_write(ir_write_1), .mem_to_reg(mem_to_reg_1),
    .reg_write(reg_write_1), .alu_src_a(alu_src_a_1), .alu_src_b(alu_src_b_1),
    .pc_source(pc_source_1), .alu_control(alu_control_1),
    .instr_retired(instr_retired_1), .illegal(illegal_1), .state(state_1));

  multicycle_control #(.ENABLE_BNE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .pc_write(pc_write_2), .i_or_d(i_or_d_2), .mem_read(mem_read_2),
    .mem_write(mem_write_2), .ir_write(ir_write_2), .mem_to_reg(mem_to_reg_2),
    .reg_write(reg_write_2), .alu_src_a(alu_src_a_2), .alu_src_b(alu_src_b_2),
    .pc_source(pc_source_2), .alu_control(alu_control_2),
    .instr_retired(instr_retired_2), .illegal(illegal_2), .state(state_2));

  always #5 clk = ~clk;

  ov_t a1, a2, e1, e2;
  assign a1 = {state_1, pc_write_1, i_or_d_1, mem_read_1, mem_write_1, ir_write_1,
               mem_to_reg_1, reg_write_1, alu_src_a_1, alu_src_b_1, pc_source_1,
               alu_control_1, instr_retired_1, illegal_1};
  assign a2 = {state_2, pc_write_2, i_or_d_2, mem_read_2, mem_write_2, ir_write_2,
               mem_to_reg_2, reg_write_2, alu_src_a_2, alu_src_b_2, pc_source_2,
               alu_control_2, instr_retired_2, illegal_2};

  ov_t q1[$];
  ov_t q2[$];
  int  checks = 0;
  int  errors = 0;

  // Fixed per-state output table; pc_write, alu_control and
  // instr_retired are supplied by the caller for each cycle.
  function automatic ov_t row(input logic [3:0] st, input logic pcw,
                              input logic [3:0] ctl, input logic ret);
    ov_t v;
    v = '0;
    v.st = st; v.pcw = pcw; v.ctl = ctl; v.ret = ret;
    case (st)
      4'd0:  begin v.mr = 1'b1; v.irw = 1'b1; v.sb = 2'b01; end
      4'd1:  begin v.sb = 2'b10; v.ps = 1'b1; end
      4'd2:  begin v.sa = 1'b1; v.sb = 2'b10; end
      4'd3:  begin v.iod = 1'b1; v.mr = 1'b1; end
      4'd4:  begin v.m2r = 1'b1; v.rw = 1'b1; end
      4'd5:  begin v.iod = 1'b1; v.mw = 1'b1; end
      4'd6:  v.sa = 1'b1;
      4'd7:  begin v.sa = 1'b1; v.sb = 2'b10; end
      4'd8:  v.rw = 1'b1;
      4'd9:  begin v.sa = 1'b1; v.ps = 1'b1; end
      4'd10: v.ill = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // FETCH outputs with the reset-masked enables cleared.
  function automatic ov_t rstv();
    ov_t v;
    v = row(4'd0, 1'b0, ADD, 1'b0);
    v.irw = 1'b0;
    return v;
  endfunction

  task automatic push(input int which, input ov_t v);
    if (which == 1) q1.push_back(v);
    else            q2.push_back(v);
  endtask

  // Expect one cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input int which, input logic [3:0] st, input logic pcw,
                     input logic [3:0] ctl, input logic ret);
    push(which, row(st, pcw, ctl, ret));
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z);
    opcode = op; funct3 = f3; funct7_b5 = f7; zero = z;
  endtask

  task automatic pulse_probe();
    probe = 1'b1;
    #1;
    probe = 1'b0;
  endtask

  // Monitor: compare each queued expectation against the live outputs.
  always begin
    @(negedge clk or posedge probe);
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      checks++;
      if (a1 !== e1) begin
        errors++;
        $display("FAIL dut1 st%0d got %h want %h", e1.st, a1, e1);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      checks++;
      if (a2 !== e2) begin
        errors++;
        $display("FAIL dut2 st%0d got %h want %h", e2.st, a2, e2);
      end
    end
    if (done) begin
      if (q1.size() != 0 || q2.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d/%0d pending want 0", q1.size(), q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    setin(7'd0, 3'd0, 1'b0, 1'b0);
    #1;
    push(1, rstv()); push(2, rstv());
    pulse_probe();
    @(posedge clk); #1;
    reset = 1'b1;

    // addi
    setin(7'b0010011, 3'b000, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd7, 0, ADD, 0); cyc(1, 4'd8, 0, ADD, 1);
    // andi, funct7_b5 ignored
    setin(7'b0010011, 3'b111, 1'b1, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd7, 0, AND_, 0); cyc(1, 4'd8, 0, ADD, 1);
    // lw
    setin(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd2, 0, ADD, 0);
    cyc(1, 4'd3, 0, ADD, 0); cyc(1, 4'd4, 0, ADD, 1);
    // sw
    setin(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd2, 0, ADD, 0);
    cyc(1, 4'd5, 0, ADD, 1);
    // R-type sub / or / and / add
    setin(7'b0110011, 3'b000, 1'b1, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd6, 0, SUB, 0); cyc(1, 4'd8, 0, ADD, 1);
    setin(7'b0110011, 3'b110, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd6, 0, OR_, 0); cyc(1, 4'd8, 0, ADD, 1);
    setin(7'b0110011, 3'b111, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd6, 0, AND_, 0); cyc(1, 4'd8, 0, ADD, 1);
    // beq taken / not taken, bne taken / not taken
    setin(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd9, 1, SUB, 1);
    setin(7'b1100011, 3'b000, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd9, 0, SUB, 1);
    setin(7'b1100011, 3'b001, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd9, 1, SUB, 1);
    setin(7'b1100011, 3'b001, 1'b0, 1'b1);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0); cyc(1, 4'd9, 0, SUB, 1);

    // Reset asserted mid-EXEC_R: FETCH immediately, enables masked
    setin(7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    push(1, row(4'd6, 0, ADD, 0));
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    push(1, rstv());
    pulse_probe();
    @(posedge clk); #1;
    push(1, rstv());
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    cyc(1, 4'd6, 0, ADD, 0); cyc(1, 4'd8, 0, ADD, 1);

    // Illegal opcode traps and stays
    setin(7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc(1, 4'd0, 0, ADD, 0); cyc(1, 4'd1, 1, ADD, 0);
    for (int i = 0; i < 10; i++) cyc(1, 4'd10, 0, ADD, 0);

    // dut2: illegal instructions retire as NOPs, bne is illegal
    reset = 1'b0;
    reset2 = 1'b1;
    setin(7'b1100011, 3'b001, 1'b0, 1'b0);
    cyc(2, 4'd0, 0, ADD, 0); cyc(2, 4'd1, 1, ADD, 1);
    setin(7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc(2, 4'd0, 0, ADD, 0); cyc(2, 4'd1, 1, ADD, 1);
    setin(7'b0100011, 3'b000, 1'b0, 1'b0);
    cyc(2, 4'd0, 0, ADD, 0); cyc(2, 4'd1, 1, ADD, 1);
    setin(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc(2, 4'd0, 0, ADD, 0); cyc(2, 4'd1, 1, ADD, 0); cyc(2, 4'd9, 1, SUB, 1);
    setin(7'b0010011, 3'b110, 1'b0, 1'b0);
    cyc(2, 4'd0, 0, ADD, 0); cyc(2, 4'd1, 1, ADD, 0);
    cyc(2, 4'd7, 0, OR_, 0); cyc(2, 4'd8, 0, ADD, 1);
    cyc(2, 4'd0, 0, ADD, 0);

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor got no summary want summary within 5 cycles");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the 32-bit RISC-V multicycle datapath (PC, unified byte memory, IR, MDR, register file, A/B/ALUOut latches, ALU, five source muxes).
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every mux select, write enable and the 4-bit ALU control code.
- Supported instructions: lw, sw, beq, bne, addi/andi/ori, add/sub/and/or.

Parameters:
- ENABLE_BNE, 1: if 1, bne (funct3 001) is legal; if 0, it is illegal.
- TRAP_ON_ILLEGAL, 1: if 1, an illegal instruction enters TRAP; if 0, it is treated as a NOP and control returns to FETCH.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset: 0 resets, 1 runs.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC load enable.
- i_or_d  out  1  Memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  Memory read enable.
- mem_write  out  1  Memory write enable.
- ir_write  out  1  IR load enable.
- mem_to_reg  out  1  Writeback select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  Register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm.
- pc_source  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- instr_retired  out  1  One-cycle pulse on the final cycle of each instruction.
- illegal  out  1  High while in TRAP.
- state  out  4  Current state encoding, for debug.

Behaviour:
- State register 4 bits. Encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, TRAP 10. Unused codes go to FETCH on the next edge.
- Reset low: state goes to FETCH immediately (asynchronously). While reset is low, pc_write, mem_write, reg_write, ir_write and instr_retired are forced 0. All other outputs take their FETCH values.
- Outputs are combinational from state (plus funct fields and zero where stated). Default for any output not listed in a state: 0, with alu_src_b=00 and alu_control=0010.
- FETCH: i_or_d=0, mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, ADD. PC is not written; ALUOut captures PC+4. Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, ADD, pc_source=1, pc_write=1.
  - PC loads ALUOut (PC+4) at the end of this cycle.
  - ALUOut captures old PC + imm, the branch target.
  - Next state by opcode: 0000011 with funct3 010 → MEM_ADDR; 0100011 with funct3 010 → MEM_ADDR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 with funct3 000 (or 001 when ENABLE_BNE=1) → BRANCH.
  - Anything else, or an unsupported funct combination, is illegal → TRAP (TRAP_ON_ILLEGAL=1) or FETCH with an instr_retired pulse (TRAP_ON_ILLEGAL=0).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: i_or_d=1, mem_read=1; MDR captures the word. Next state MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_retired=1. Next state FETCH.
- MEM_WRITE: i_or_d=1, mem_write=1, instr_retired=1. Next state FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00. ALU function:
  - funct3 000 with funct7_b5=0 → ADD; funct3 000 with funct7_b5=1 → SUB.
  - funct3 111 → AND; funct3 110 → OR.
  - Next state ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10. funct3 000 → ADD, 111 → AND, 110 → OR. funct7_b5 is ignored. Next state ALU_WB.
- ALU_WB: mem_to_reg=0, reg_write=1, instr_retired=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=1, instr_retired=1. pc_write = zero for beq, ~zero for bne. Next state FETCH.
- TRAP: all enables 0, illegal=1. Stays in TRAP until reset.
- Latency in cycles: lw 5, sw 4, R-type 4, I-type ALU 4, branch 3.

Test Plan:
- Reset low mid-EXEC_R (state=6) → state=0 immediately with reg_write=0. After release, the first edge goes to DECODE (state=1).
- opcode 0010011, funct3 000 (addi) → states 0,1,7,8,0. Cycle 3: alu_src_b=10, alu_control=0010. Cycle 4: reg_write=1, mem_to_reg=0, instr_retired=1.
- opcode 0000011, funct3 010 (lw) → states 0,1,2,3,4. In state 3: i_or_d=1, mem_read=1. In state 4: mem_to_reg=1, reg_write=1. sw (0100011) → states 0,1,2,5 with mem_write=1 only in state 5.
- opcode 0110011, funct3 000, funct7_b5=1 → alu_control=0110 in EXEC_R. Same with funct3 110 → 0001; funct3 111 → 0000.
- beq (1100011, funct3 000) with zero=1 in BRANCH → pc_write=1, pc_source=1; with zero=0 → pc_write=0. bne with zero=0 → pc_write=1. In both cases pc_write=1 in DECODE.
- opcode 1111111 → TRAP (state=10, illegal=1, no enables) held for 10 cycles. With TRAP_ON_ILLEGAL=0 → returns to state 0 after DECODE with instr_retired=1.
